// File: rtl/xy_slot_if.sv
// X/Y slot scheduler bus: drawing sources on one side,
// DAC output registers on the other.
interface xy_slot_if;
  logic [3:0]  src_en;
  logic [31:0] x_in;
  logic [31:0] y_in;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic [7:0]  x_out;
  logic [7:0]  y_out;
  logic        blank;
  logic        frame_tick;

  modport master (
    output src_en, x_in, y_in,
    input  grant, sel, x_out, y_out, blank, frame_tick
  );

  modport slave (
    input  src_en, x_in, y_in,
    output grant, sel, x_out, y_out, blank, frame_tick
  );
endinterface

// File: rtl/xy_slot_scheduler.sv
// Round-robin time multiplexer of four point streams onto
// one X/Y DAC pair, with a blanked settle before each switch.
module xy_slot_scheduler #(
  parameter int SLOT_LEN   = 64,
  parameter int SETTLE_LEN = 4
) (
  input logic     clk,
  input logic     rst_n,
  xy_slot_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DRAW
  } state_e;

  localparam logic [9:0] SLOT_LD   = 10'(SLOT_LEN - 1);
  localparam logic [9:0] SETTLE_LD = 10'(SETTLE_LEN - 1);

  state_e      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic        blank_q, blank_d;
  logic        tick_q, tick_d;

  logic        found;
  logic [1:0]  nxt;
  logic [7:0]  x_pt;
  logic [7:0]  y_pt;

  assign x_pt = bus.x_in[{sel_q, 3'b000} +: 8];
  assign y_pt = bus.y_in[{sel_q, 3'b000} +: 8];

  // Next enabled source after sel, wrapping back to sel itself.
  always_comb begin
    found = |bus.src_en;
    nxt   = sel_q;
    for (int i = 4; i >= 1; i--) begin
      if (bus.src_en[sel_q + 2'(i)]) nxt = sel_q + 2'(i);
    end
  end

  // Slot sequencing and DAC sample selection.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    blank_d = blank_q;
    tick_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        blank_d = 1'b1;
        if (found) begin
          sel_d   = nxt;
          tick_d  = (nxt <= sel_q);
          cnt_d   = SETTLE_LD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        blank_d = 1'b1;
        x_d     = x_pt;
        y_d     = y_pt;
        if (!bus.src_en[sel_q]) begin
          if (found) begin
            sel_d  = nxt;
            tick_d = (nxt <= sel_q);
            cnt_d  = SETTLE_LD;
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_q == '0) begin
          cnt_d   = SLOT_LD;
          state_d = DRAW;
        end else begin
          cnt_d = cnt_q - 10'd1;
        end
      end
      DRAW: begin
        x_d     = x_pt;
        y_d     = y_pt;
        blank_d = 1'b0;
        if (cnt_q == '0 || !bus.src_en[sel_q]) begin
          if (!found) begin
            state_d = IDLE;
            blank_d = 1'b1;
            x_d     = x_q;
            y_d     = y_q;
          end else if (nxt == sel_q) begin
            cnt_d  = SLOT_LD;
            tick_d = 1'b1;
          end else begin
            sel_d   = nxt;
            tick_d  = (nxt <= sel_q);
            cnt_d   = SETTLE_LD;
            state_d = SETTLE;
            blank_d = 1'b1;
            x_d     = x_q;
            y_d     = y_q;
          end
        end else begin
          cnt_d = cnt_q - 10'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, selection and DAC output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd3;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      blank_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      blank_q <= blank_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.grant      = (state_q == DRAW) ? (4'b0001 << sel_q) : 4'b0000;
  assign bus.sel        = sel_q;
  assign bus.x_out      = x_q;
  assign bus.y_out      = y_q;
  assign bus.blank      = blank_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_xy_slot_scheduler.sv
// Directed bench for xy_slot_scheduler with short slots
// (SLOT_LEN=4, SETTLE_LEN=2) and hand-derived cycle timelines.
module tb_xy_slot_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [7:0] x0 = 8'h11;
  logic [7:0] x1 = 8'h22;
  logic [7:0] x2 = 8'hA5;
  logic [7:0] x3 = 8'h44;

  xy_slot_if bus ();

  assign bus.x_in = {x3, x2, x1, x0};
  assign bus.y_in = 32'h4B5A_3C2D;

  xy_slot_scheduler #(
    .SLOT_LEN   (4),
    .SETTLE_LEN (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Source 2 advances its ramp on every consumed point.
  always @(posedge clk) begin
    if (bus.grant[2]) x2 <= x2 + 8'd1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] en);
    rst_n = 1'b0;
    bus.src_en = en;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.src_en = 4'b0000;
    step();
    // reset values
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_blank", 32'(bus.blank), 32'h1);
    check("rst_x", 32'(bus.x_out), 32'h0);
    check("rst_y", 32'(bus.y_out), 32'h0);
    check("rst_tick", 32'(bus.frame_tick), 32'h0);
    check("rst_sel", 32'(bus.sel), 32'h3);

    // full rotation 0,1,2,3,0 with the ramp on source 2
    do_reset(4'b1111);
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 6; c++) begin
        int s;
        s = k % 4;
        step();
        check($sformatf("rot%0d_c%0d_sel", k, c),
              32'(bus.sel), 32'(s));
        check($sformatf("rot%0d_c%0d_tick", k, c),
              32'(bus.frame_tick), (c == 0 && s == 0) ? 32'h1 : 32'h0);
        check($sformatf("rot%0d_c%0d_grant", k, c),
              32'(bus.grant), (c >= 2) ? (32'h1 << s) : 32'h0);
        check($sformatf("rot%0d_c%0d_blank", k, c),
              32'(bus.blank), (c <= 2) ? 32'h1 : 32'h0);
        if (k == 2 && c >= 1) begin
          check($sformatf("ramp_c%0d_x", c), 32'(bus.x_out),
                (c <= 2) ? 32'hA5 : 32'(8'hA5 + 8'(c - 3)));
        end
        if (k == 2 && c == 3)
          check("ramp_y", 32'(bus.y_out), 32'h5A);
      end
    end

    // single source: continuous draw, tick every slot
    do_reset(4'b0100);
    step();
    check("single_c1_sel", 32'(bus.sel), 32'h2);
    check("single_c1_tick", 32'(bus.frame_tick), 32'h1);
    step();
    step();
    for (int c = 4; c <= 16; c++) begin
      step();
      check($sformatf("single_c%0d_grant", c), 32'(bus.grant), 32'h4);
      check($sformatf("single_c%0d_blank", c), 32'(bus.blank), 32'h0);
      check($sformatf("single_c%0d_sel", c), 32'(bus.sel), 32'h2);
      check($sformatf("single_c%0d_tick", c), 32'(bus.frame_tick),
            (c == 7 || c == 11 || c == 15) ? 32'h1 : 32'h0);
    end

    // drop current source mid-DRAW, skip disabled source 2
    do_reset(4'b1011);
    for (int c = 1; c <= 10; c++) step();
    check("drop_c10_grant", 32'(bus.grant), 32'h2);
    bus.src_en = 4'b1001;
    step();
    check("drop_c11_grant", 32'(bus.grant), 32'h0);
    check("drop_c11_blank", 32'(bus.blank), 32'h1);
    check("drop_c11_sel", 32'(bus.sel), 32'h3);
    check("drop_c11_tick", 32'(bus.frame_tick), 32'h0);
    step();
    step();
    check("drop_c13_grant", 32'(bus.grant), 32'h8);
    step();
    check("drop_c14_x", 32'(bus.x_out), 32'h44);
    check("drop_c14_blank", 32'(bus.blank), 32'h0);

    // all enables drop: IDLE with frozen coordinates
    bus.src_en = 4'b0000;
    step();
    check("idle_c15_blank", 32'(bus.blank), 32'h1);
    check("idle_c15_grant", 32'(bus.grant), 32'h0);
    x3 = 8'h99;
    step();
    step();
    check("idle_c17_x", 32'(bus.x_out), 32'h44);
    check("idle_c17_y", 32'(bus.y_out), 32'h4B);
    check("idle_c17_blank", 32'(bus.blank), 32'h1);
    check("idle_c17_grant", 32'(bus.grant), 32'h0);
    bus.src_en = 4'b0001;
    step();
    check("reen_c18_sel", 32'(bus.sel), 32'h0);
    check("reen_c18_tick", 32'(bus.frame_tick), 32'h1);
    check("reen_c18_blank", 32'(bus.blank), 32'h1);
    step();
    check("reen_c19_x", 32'(bus.x_out), 32'h11);
    check("reen_c19_grant", 32'(bus.grant), 32'h0);
    step();
    check("reen_c20_grant", 32'(bus.grant), 32'h1);
    check("reen_c20_blank", 32'(bus.blank), 32'h1);
    step();
    check("reen_c21_blank", 32'(bus.blank), 32'h0);
    check("reen_c21_x", 32'(bus.x_out), 32'h11);
    check("reen_c21_y", 32'(bus.y_out), 32'h2D);

    // asynchronous reset in the middle of DRAW
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_grant", 32'(bus.grant), 32'h0);
    check("arst_blank", 32'(bus.blank), 32'h1);
    check("arst_x", 32'(bus.x_out), 32'h0);
    check("arst_y", 32'(bus.y_out), 32'h0);
    check("arst_sel", 32'(bus.sel), 32'h3);
    bus.src_en = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("arst_post_sel", 32'(bus.sel), 32'h0);
    check("arst_post_tick", 32'(bus.frame_tick), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xy_slot_scheduler.md
Name: xy_slot_scheduler

Overview:
- Time-multiplexes the single X/Y DAC pair between four point-stream drawing sources: 0 = border, 1 = left paddle, 2 = right paddle, 3 = ball.
- Each enabled source gets a fixed dwell slot in round-robin order. A blanked settle interval precedes each source switch so the oscilloscope beam can move without drawing a trace.
- Sits between the drawing generators and the DAC output registers.

Parameters:
- SLOT_LEN, 64: DRAW cycles granted per slot; range 1..1023.
- SETTLE_LEN, 4: blanked cycles before drawing a newly selected source; range 1..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- src_en  in  4  per-source enable; bit k = source k.
- x_in  in  32  source X coordinates, packed; source k at bits [8k+7:8k].
- y_in  in  32  source Y coordinates, packed the same way.
- grant  out  4  one-hot; bit k high = source k's current point is consumed this cycle and the source advances.
- sel  out  2  index of the currently selected source.
- x_out  out  8  registered X to DAC.
- y_out  out  8  registered Y to DAC.
- blank  out  1  registered beam blank; 1 = do not draw.
- frame_tick  out  1  one-cycle pulse when the rotation wraps.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - state = IDLE, sel = 3 (internal so the first search starts at 0).
  - x_out = 0, y_out = 0, blank = 1.
  - grant = 0, frame_tick = 0, slot counter = 0.
- Next-source search (combinational):
  - Scan (sel+1), (sel+2), (sel+3), (sel+4) mod 4.
  - The first index with src_en set is nxt. found = |src_en.
- States:
  - IDLE:
    - Outputs: blank = 1, grant = 0; x_out/y_out hold.
    - If found: sel <= nxt, counter <= SETTLE_LEN-1, go to SETTLE.
  - SETTLE:
    - Outputs: blank = 1, grant = 0; x_out/y_out <= x_in/y_in of sel every cycle (beam tracks the new source's held first point).
    - If !src_en[sel]: re-search. If found, go to SETTLE on nxt with the counter reloaded; otherwise go to IDLE.
    - Else if counter == 0: counter <= SLOT_LEN-1, go to DRAW.
    - Else: decrement counter.
  - DRAW:
    - Outputs: grant[sel] = 1 (decoded from registered state and sel, no input path); x_out/y_out <= source sel coordinates; blank <= 0.
    - Latency: one cycle. The point granted in cycle t appears on x_out/y_out with blank = 0 in cycle t+1.
    - Slot end (counter == 0) or src_en[sel] dropped: search.
      - nxt == sel (only one source enabled): stay in DRAW, reload counter to SLOT_LEN-1, no settle, blank stays 0.
      - nxt != sel: sel <= nxt, go to SETTLE, blank <= 1 next cycle.
      - Not found: go to IDLE, blank <= 1.
- The blank register is updated with the same edge as x_out/y_out, so blank and coordinates always describe the same sample.
- frame_tick = 1 for exactly one cycle whenever sel is loaded with a value ≤ its previous value. This includes IDLE leaving to source 0 after reset, and the single-source reload in DRAW.
- src_en changes mid-slot: only the current source's bit terminates the slot. Other bits are sampled only at the search.
- Counter is 10 bits. Zero-length parameters are illegal; the implementation is not required to handle them.
- Reset mid-slot: immediate return to reset values; grant drops asynchronously.

Test Plan:
- Reset, then src_en = 4'b1111, SLOT_LEN = 4, SETTLE_LEN = 2 -> sel sequence 0,1,2,3,0. Each slot is 2 blank cycles then 4 grant cycles; frame_tick pulses at the start of source 0 only.
- Source 2 holds x = 8'hA5 in SETTLE, then ramps during DRAW -> x_out = A5 while blank = 1. Each granted value appears on x_out one cycle later with blank = 0. Exactly SLOT_LEN grant pulses.
- src_en = 4'b0100 only -> sel stays 2, grant[2] continuously high after the first settle, blank never reasserts, frame_tick pulses every SLOT_LEN cycles.
- src_en = 4'b1011, deassert bit 1 midway through source 1's DRAW -> next cycle grant = 0 and blank = 1. Then settle on source 3; source 2 is skipped.
- All enables drop during DRAW -> IDLE, blank = 1, x_out/y_out frozen at the last value. Re-enable bit 0 -> settle on 0 then draw.
- Assert rst_n = 0 asynchronously mid-DRAW -> grant = 0, blank = 1, x_out = y_out = 0 before the next clk edge. After release, the first slot is source 0.
